fetch_unit: RTL and testbench

- Instruction fetch stage that sits upstream of the instruction decoder.
- Generates sequential word addresses to instruction memory using a valid/ready request and in-order response protocol.
- Buffers returned instructions with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing buffered and in-flight fetches.

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a credit-limited prefetch FIFO.
// Requests go out in order; responses come back in order and are buffered with
// their PCs. A redirect flushes the FIFO, drops every in-flight response and
// restarts fetch at the word-aligned target.
// Optional macro FETCH_BYPASS_EN: when the FIFO is empty, a kept response is
// presented to decode in the same cycle it returns from memory.
module fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned           FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [DATA_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
);

    localparam int unsigned           CW       = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned           AW       = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]           CREDITS  = (CW+1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] PC_ALIGN = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

    logic [DATA_WIDTH-1:0] r_fetch_pc;
    logic [DATA_WIDTH-1:0] r_resp_pc;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_drop;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_wr_ptr;
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];

    logic [DATA_WIDTH-1:0] w_redirect_pc;
    logic [CW:0]           w_inflight;
    logic                  w_req_valid;
    logic                  w_accept;
    logic                  w_keep;
    logic                  w_drop_resp;
    logic                  w_fifo_nonempty;
    logic                  w_bypass;
    logic                  w_pop;
    logic                  w_push;

    assign w_redirect_pc   = redirect_pc & PC_ALIGN;
    assign w_inflight      = {1'b0, r_count} + {1'b0, r_outstanding};
    // Every issued request owns a FIFO slot until its word is popped or dropped.
    assign w_req_valid     = rst_n && !redirect_valid && (w_inflight < CREDITS);
    assign w_accept        = w_req_valid && imem_req_ready;
    assign w_keep          = imem_resp_valid && (r_drop == '0);
    assign w_drop_resp     = imem_resp_valid && (r_drop != '0);
    assign w_fifo_nonempty = (r_count != '0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = rst_n && w_keep && !w_fifo_nonempty && !redirect_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pop  = w_fifo_nonempty && inst_ready;
    // A bypassed word that decode takes immediately never enters the FIFO.
    assign w_push = w_keep && !(w_bypass && inst_ready);

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign inst_valid     = w_fifo_nonempty || w_bypass;
    assign inst_data      = w_fifo_nonempty ? r_fifo_data[r_rd_ptr] :
                            (w_bypass ? imem_resp_data : '0);
    assign inst_pc        = w_fifo_nonempty ? r_fifo_pc[r_rd_ptr] :
                            (w_bypass ? r_resp_pc : '0);

    // Fetch/response PCs, outstanding-request credit and stale-response drop count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                // No request is accepted in a redirect cycle, so everything
                // still outstanding after this cycle belongs to the old stream.
                r_drop     <= r_outstanding - CW'(imem_resp_valid);
            end else begin
                if (w_accept)    r_fetch_pc <= r_fetch_pc + PC_STEP;
                if (w_keep)      r_resp_pc  <= r_resp_pc + PC_STEP;
                if (w_drop_resp) r_drop     <= r_drop - CW'(1);
            end
        end
    end

    // Prefetch FIFO pointers and occupancy; a redirect empties it outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (redirect_valid) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Prefetch FIFO storage: instruction word and the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (w_push && !redirect_valid) begin
            r_fifo_data[r_wr_ptr] <= imem_resp_data;
            r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

    // Credits guarantee a free slot for every kept response.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && !redirect_valid && (r_count == CW'(FIFO_DEPTH))))
        else $error("fetch_unit: push into full prefetch FIFO");

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: stream-level scoreboard plus in-order memory model for fetch_unit.
module tb_fetch_unit;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] addr; int due; int ep; } req_t;
    typedef struct { logic [31:0] target; int n_acc; logic [31:0] exp_pc0; logic [31:0] exp_pc1; } redir_vec_t;

    req_t        pend[$];
    logic [31:0] del_pcs[$];
    logic [31:0] acc_addrs[$];
    redir_vec_t  vecs[5];
    int          cyc = 0;
    int          last_due = 0;
    int          epoch = 0;
    int          resp_ep = 0;
    int          buffered = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          first_resp = -1;
    int          first_valid = -1;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] exp_req = RST_PC;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_del(input string name, input int idx, input logic [31:0] exp);
        if (idx < del_pcs.size()) chk(name, del_pcs[idx], exp);
        else begin
            checks++; errors++;
            $display("FAIL %s: instruction %0d never delivered, expected pc %h", name, idx, exp);
        end
    endtask

    task automatic chk_acc0(input string name, input logic [31:0] exp);
        if (acc_addrs.size() > 0) chk(name, acc_addrs[0], exp);
        else begin
            checks++; errors++;
            $display("FAIL %s: no request accepted, expected addr %h", name, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_acc(input string name, input int n, input int limit);
        int k = 0;
        while (acc_addrs.size() < n && k < limit) begin
            @(negedge clk); #1; k++;
        end
        if (acc_addrs.size() < n) begin
            checks++; errors++;
            $display("FAIL %s: %0d requests accepted, expected %0d within %0d cycles",
                     name, acc_addrs.size(), n, limit);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        first_resp = -1;
        first_valid = -1;
    endtask

    // In-order memory: drives at most one due response per cycle.
    initial forever begin
        @(posedge clk); #1;
        cyc++;
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memfn(pend[0].addr);
            resp_ep         = pend[0].ep;
            pend.delete(0);
        end
    end

    // Stream scoreboard: the decoder must see an unbroken +4 PC sequence per epoch.
    always @(negedge clk) begin : sb
        int  out_start;
        int  lat;
        int  due;
        bit  kept;
        if (!rst_n) begin
            pend.delete();
            del_pcs.delete();
            acc_addrs.delete();
            buffered = 0;
            epoch++;
            last_due = 0;
            exp_pc = RST_PC;
            exp_req = RST_PC;
        end else begin
            kept = imem_resp_valid && (resp_ep == epoch) && !redirect_valid;
            out_start = pend.size() + int'(imem_resp_valid);
            chk("req_valid", imem_req_valid,
                !redirect_valid && (buffered + out_start < DEPTH));
`ifdef FETCH_BYPASS_EN
            chk("inst_valid", inst_valid, (buffered > 0) || kept);
`else
            chk("inst_valid", inst_valid, buffered > 0);
`endif
            if (imem_resp_valid && first_resp < 0) first_resp = cyc;
            if (inst_valid && first_valid < 0) first_valid = cyc;
            if (kept) buffered++;
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_req);
                acc_addrs.push_back(imem_req_addr);
                exp_req += 32'd4;
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: imem_req_addr, due: due, ep: epoch});
            end
            if (inst_valid) begin
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst_data", inst_data, memfn(exp_pc));
                if (inst_ready) begin
                    del_pcs.push_back(inst_pc);
                    exp_pc += 32'd4;
                    if (buffered > 0) buffered--;
                end
            end
            if (redirect_valid) begin
                epoch++;
                buffered = 0;
                exp_pc  = redirect_pc & 32'hFFFF_FFFC;
                exp_req = redirect_pc & 32'hFFFF_FFFC;
                del_pcs.delete();
                acc_addrs.delete();
            end
            chk("credit", (buffered + pend.size()) <= DEPTH, 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0102, 3, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'h0000_0103, 0, 32'h0000_0100, 32'h0000_0104};
        vecs[2] = '{32'hFFFF_FFFE, 4, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h1234_5679, 1, 32'h1234_5678, 32'h1234_567C};
        vecs[4] = '{32'h0000_0040, 2, 32'h0000_0040, 32'h0000_0044};

        // Reset state, then a plain sequential stream.
        inst_ready = 1'b1;
        imem_req_ready = 1'b1;
        tick(); tick();
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        rst_n = 1'b1;
        repeat (8) tick();
        chk_del("seq_pc0", 0, 32'h0);
        chk_del("seq_pc1", 1, 32'h4);
        chk_del("seq_pc2", 2, 32'h8);
        chk_del("seq_pc3", 3, 32'hC);
`ifdef FETCH_BYPASS_EN
        chk("first_latency", first_valid - first_resp, 32'd0);
`else
        chk("first_latency", first_valid - first_resp, 32'd1);
`endif

        // Decoder stalled: credits cap the requests at FIFO_DEPTH.
        inst_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        chk("stall_acc", acc_addrs.size(), DEPTH);
        @(negedge clk);
        chk("stall_req_valid", imem_req_valid, 1'b0);
        chk("stall_inst_valid", inst_valid, 1'b1);
        chk("stall_inst_pc", inst_pc, 32'h0);
        tick();
        inst_ready = 1'b1;
        repeat (12) tick();
        for (int i = 0; i < 5; i++) chk_del("stall_release", i, 32'(4 * i));

        // Redirect table: target, requests in flight, first two PCs after redirect.
        lat_min = 6; lat_max = 6;
        for (int i = 0; i < 5; i++) begin
            do_reset();
            if (vecs[i].n_acc > 0) begin
                wait_acc("redir_wait", vecs[i].n_acc, 20);
                tick();
            end
            redirect_valid = 1'b1;
            redirect_pc = vecs[i].target;
            tick();
            redirect_valid = 1'b0;
            repeat (30) tick();
            chk_acc0("redir_req_addr", vecs[i].exp_pc0);
            chk_del("redir_pc0", 0, vecs[i].exp_pc0);
            chk_del("redir_pc1", 1, vecs[i].exp_pc1);
        end

        // Redirect colliding with a pop, a push and a stalled request.
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (6) tick();
        imem_req_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
`ifndef FETCH_BYPASS_EN
        chk("coll_pop_valid", inst_valid, 1'b1);
`endif
        chk("coll_withdrawn", imem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("coll_empty", inst_valid, 1'b0);
        chk("coll_req_valid", imem_req_valid, 1'b1);
        chk("coll_req_addr", imem_req_addr, 32'h0000_0200);
        repeat (20) tick();
        chk_del("coll_pc0", 0, 32'h0000_0200);
        chk_del("coll_pc1", 1, 32'h0000_0204);

        // Random memory readiness, latency, decoder stalls and redirects.
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            imem_req_ready = ($urandom % 2) == 1;
            inst_ready = ($urandom % 10) < 7;
            if (i == 300 || i == 301 || ($urandom % 25) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        repeat (20) tick();

        // Asynchronous reset with two requests in flight.
        lat_min = 5; lat_max = 5;
        do_reset();
        wait_acc("mr_wait", 2, 20);
        tick();
        imem_req_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_req_valid", imem_req_valid, 1'b0);
        chk("mr_inst_valid", inst_valid, 1'b0);
        chk("mr_inst_data", inst_data, 32'h0);
        chk("mr_inst_pc", inst_pc, 32'h0);
        tick(); tick();
        imem_req_ready = 1'b1;
        rst_n = 1'b1;
        repeat (12) tick();
        chk_acc0("mr_restart_addr", RST_PC);
        chk_del("mr_restart_pc", 0, RST_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
